ising_run_ctrl: RTL and testbench

- Sequencer that drives one ising_axi instance through a complete solve, replacing testbench-style manual programming.
- Solve sequence: program counter cutoff/max, stream coupling weights, issue START, wait a programmable anneal time, read back all N phases.
- Sits between a host-side command/weight stream and the ising_axi write and read ports.
- Addresses come from the shared ising_axi `define header: CTR_CUTOFF_ADDR, CTR_MAX_ADDR, WEIGHT_ADDR_BASE, START_ADDR, PHASE_ADDR_BASE.

---
 rtl/ising_run_ctrl.sv | 275 +++++++++++++++++++++++++++
 tb/tb_ising_run_ctrl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ising_run_ctrl.sv
// ising_run_ctrl: drives one ising_axi instance through a complete solve.
// It programs the counter cutoff and max, streams the coupling weights,
// issues START, waits the anneal time, then reads back every spin phase.
//
// Ports
//   clk, axi_rstn           clock, async active-low reset
//   start, cfg_cutoff,      solve launch pulse and its configuration
//   cfg_max, run_cycles     (all sampled on the accepted start)
//   busy, done, err         solve in progress, completion pulse, sticky bad-weight flag
//   w_valid/w_ready/w_i/    host weight stream (one entry per handshake,
//   w_j/w_data/w_last       w_last marks the final entry)
//   wready/wr_addr/wdata    single-cycle write strobe toward ising_axi
//   araddr/rdata            read port toward ising_axi
//   ph_valid/ph_ready/      phase results, one per spin, in spin order
//   ph_idx/ph_data
//
// state | meaning
// IDLE  | waiting for start
// CUT   | writing the counter cutoff
// MAX   | writing the counter max
// LOAD  | accepting weight entries (w_ready high)
// WGT   | writing the weight accepted in the previous cycle
// STRT  | writing START_WORD
// RUN   | anneal wait, counting run_cycles down
// RADDR | read address presented, waiting for rdata to settle
// ROUT  | phase result presented, waiting for ph_ready

`ifndef CTR_CUTOFF_ADDR
`define CTR_CUTOFF_ADDR 32'h0000_0004
`endif
`ifndef CTR_MAX_ADDR
`define CTR_MAX_ADDR 32'h0000_0008
`endif
`ifndef WEIGHT_ADDR_BASE
`define WEIGHT_ADDR_BASE 32'h0010_0000
`endif
`ifndef START_ADDR
`define START_ADDR 32'h0000_0000
`endif
`ifndef PHASE_ADDR_BASE
`define PHASE_ADDR_BASE 32'h0000_1000
`endif

module ising_run_ctrl #(
  parameter int          N          = 8,
  parameter int          IW         = $clog2(N),
  parameter logic [31:0] START_WORD = 32'h0000_0010,
  parameter int          READ_LAT   = 1
) (
  input  logic          clk,
  input  logic          axi_rstn,
  input  logic          start,
  input  logic [31:0]   cfg_cutoff,
  input  logic [31:0]   cfg_max,
  input  logic [31:0]   run_cycles,
  output logic          busy,
  output logic          done,
  output logic          err,
  input  logic          w_valid,
  output logic          w_ready,
  input  logic [IW-1:0] w_i,
  input  logic [IW-1:0] w_j,
  input  logic [31:0]   w_data,
  input  logic          w_last,
  output logic          wready,
  output logic [31:0]   wr_addr,
  output logic [31:0]   wdata,
  output logic [31:0]   araddr,
  input  logic [31:0]   rdata,
  output logic          ph_valid,
  input  logic          ph_ready,
  output logic [IW-1:0] ph_idx,
  output logic [31:0]   ph_data
);

  typedef enum logic [3:0] {
    S_IDLE, S_CUT, S_MAX, S_LOAD, S_WGT, S_STRT, S_RUN, S_RADDR, S_ROUT
  } state_t;

  localparam logic [IW-1:0] K_LAST = IW'(N - 1);

  state_t        state_q, state_d;
  logic [31:0]   max_q, max_d;
  logic [31:0]   cnt_q, cnt_d;
  logic          last_q, last_d;
  logic [IW-1:0] k_q, k_d;
  logic          busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic          w_ready_q, w_ready_d, wready_q, wready_d;
  logic [31:0]   wr_addr_q, wr_addr_d, wdata_q, wdata_d, araddr_q, araddr_d;
  logic          ph_valid_q, ph_valid_d;
  logic [IW-1:0] ph_idx_q, ph_idx_d;
  logic [31:0]   ph_data_q, ph_data_d;

  // Spin k sits in the reversed phase slot of ising_axi.
  function automatic logic [31:0] phase_addr(input logic [IW-1:0] k);
    return `PHASE_ADDR_BASE + ((32'(N - 1) - 32'(k)) << 2);
  endfunction

  always_comb begin
    state_d    = state_q;
    max_d      = max_q;
    cnt_d      = cnt_q;
    last_d     = last_q;
    k_d        = k_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = err_q;
    w_ready_d  = 1'b0;
    wready_d   = 1'b0;
    wr_addr_d  = wr_addr_q;
    wdata_d    = wdata_q;
    araddr_d   = araddr_q;
    ph_valid_d = ph_valid_q;
    ph_idx_d   = ph_idx_q;
    ph_data_d  = ph_data_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          // cnt holds run_cycles untouched until STRT hands it to the anneal wait.
          max_d     = cfg_max;
          cnt_d     = run_cycles;
          busy_d    = 1'b1;
          err_d     = 1'b0;
          wready_d  = 1'b1;
          wr_addr_d = `CTR_CUTOFF_ADDR;
          wdata_d   = cfg_cutoff;
          state_d   = S_CUT;
        end
      end
      S_CUT: begin
        wready_d  = 1'b1;
        wr_addr_d = `CTR_MAX_ADDR;
        wdata_d   = max_q;
        state_d   = S_MAX;
      end
      S_MAX: begin
        w_ready_d = 1'b1;
        state_d   = S_LOAD;
      end
      S_LOAD: begin
        w_ready_d = 1'b1;
        if (w_valid && w_ready_q) begin
          if (w_i > w_j) begin
            // Lower-triangle entry: dropped, flagged, stream continues.
            err_d = 1'b1;
            if (w_last) begin
              w_ready_d = 1'b0;
              wready_d  = 1'b1;
              wr_addr_d = `START_ADDR;
              wdata_d   = START_WORD;
              state_d   = S_STRT;
            end
          end else begin
            w_ready_d = 1'b0;
            wready_d  = 1'b1;
            wr_addr_d = `WEIGHT_ADDR_BASE + (32'(w_i) << 2) + (32'(w_j) << 13);
            wdata_d   = w_data;
            last_d    = w_last;
            state_d   = S_WGT;
          end
        end
      end
      S_WGT: begin
        if (last_q) begin
          wready_d  = 1'b1;
          wr_addr_d = `START_ADDR;
          wdata_d   = START_WORD;
          state_d   = S_STRT;
        end else begin
          w_ready_d = 1'b1;
          state_d   = S_LOAD;
        end
      end
      S_STRT: begin
        if (cnt_q == 32'd0) begin
          k_d      = '0;
          araddr_d = phase_addr('0);
          cnt_d    = 32'(READ_LAT);
          state_d  = S_RADDR;
        end else begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // RUN lasts exactly run_cycles cycles.
        if (cnt_q <= 32'd1) begin
          k_d      = '0;
          araddr_d = phase_addr('0);
          cnt_d    = 32'(READ_LAT);
          state_d  = S_RADDR;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      S_RADDR: begin
        if (cnt_q == 32'd0) begin
          ph_valid_d = 1'b1;
          ph_idx_d   = k_q;
          ph_data_d  = rdata;
          state_d    = S_ROUT;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      S_ROUT: begin
        if (ph_ready) begin
          ph_valid_d = 1'b0;
          if (k_q == K_LAST) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            k_d      = k_q + 1'b1;
            araddr_d = phase_addr(k_q + 1'b1);
            cnt_d    = 32'(READ_LAT);
            state_d  = S_RADDR;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge axi_rstn) begin
    if (!axi_rstn) begin
      state_q    <= S_IDLE;
      max_q      <= '0;
      cnt_q      <= '0;
      last_q     <= 1'b0;
      k_q        <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      w_ready_q  <= 1'b0;
      wready_q   <= 1'b0;
      wr_addr_q  <= '0;
      wdata_q    <= '0;
      araddr_q   <= '0;
      ph_valid_q <= 1'b0;
      ph_idx_q   <= '0;
      ph_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      max_q      <= max_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
      k_q        <= k_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      w_ready_q  <= w_ready_d;
      wready_q   <= wready_d;
      wr_addr_q  <= wr_addr_d;
      wdata_q    <= wdata_d;
      araddr_q   <= araddr_d;
      ph_valid_q <= ph_valid_d;
      ph_idx_q   <= ph_idx_d;
      ph_data_q  <= ph_data_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign w_ready  = w_ready_q;
  assign wready   = wready_q;
  assign wr_addr  = wr_addr_q;
  assign wdata    = wdata_q;
  assign araddr   = araddr_q;
  assign ph_valid = ph_valid_q;
  assign ph_idx   = ph_idx_q;
  assign ph_data  = ph_data_q;

endmodule

// File: tb/tb_ising_run_ctrl.sv
`timescale 1ns/1ps

`ifndef CTR_CUTOFF_ADDR
`define CTR_CUTOFF_ADDR 32'h0000_0004
`endif
`ifndef CTR_MAX_ADDR
`define CTR_MAX_ADDR 32'h0000_0008
`endif
`ifndef WEIGHT_ADDR_BASE
`define WEIGHT_ADDR_BASE 32'h0010_0000
`endif
`ifndef START_ADDR
`define START_ADDR 32'h0000_0000
`endif
`ifndef PHASE_ADDR_BASE
`define PHASE_ADDR_BASE 32'h0000_1000
`endif

module tb_ising_run_ctrl;
  localparam int          N          = 8;
  localparam int          IW         = $clog2(N);
  localparam logic [31:0] START_WORD = 32'h0000_0010;
  localparam logic [31:0] PH_FIRST   = `PHASE_ADDR_BASE + 32'((N - 1) * 4);

  logic          clk = 1'b0;
  logic          axi_rstn, start, w_valid, w_last, ph_ready;
  logic [31:0]   cfg_cutoff, cfg_max, run_cycles, w_data, rdata;
  logic [IW-1:0] w_i, w_j;
  logic          busy, done, err, w_ready, wready, ph_valid;
  logic [31:0]   wr_addr, wdata, araddr, ph_data;
  logic [IW-1:0] ph_idx;

  always #5 clk = ~clk;

  ising_run_ctrl #(.N(N), .START_WORD(START_WORD), .READ_LAT(1)) dut (
    .clk(clk), .axi_rstn(axi_rstn), .start(start),
    .cfg_cutoff(cfg_cutoff), .cfg_max(cfg_max), .run_cycles(run_cycles),
    .busy(busy), .done(done), .err(err),
    .w_valid(w_valid), .w_ready(w_ready), .w_i(w_i), .w_j(w_j),
    .w_data(w_data), .w_last(w_last),
    .wready(wready), .wr_addr(wr_addr), .wdata(wdata),
    .araddr(araddr), .rdata(rdata),
    .ph_valid(ph_valid), .ph_ready(ph_ready), .ph_idx(ph_idx), .ph_data(ph_data)
  );

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  typedef struct packed { logic [31:0] addr; logic [31:0] data; } wr_t;
  wr_t         exp_wr[$];
  wr_t         mon_e;
  logic [31:0] exp_ph[$];
  logic [31:0] spin_val [N];
  logic [31:0] got_ph [N];

  // ising_axi read model: phase of spin k at reversed slot, one cycle of latency.
  function automatic logic [31:0] phase_model(input logic [31:0] a);
    int slot;
    if (a >= `PHASE_ADDR_BASE && a < `PHASE_ADDR_BASE + 32'(4 * N)) begin
      slot = int'((a - `PHASE_ADDR_BASE) >> 2);
      return spin_val[N - 1 - slot];
    end
    return 32'hDEAD_BEEF;
  endfunction

  always @(posedge clk) rdata <= phase_model(araddr);

  // Write scoreboard: every strobe must match the next expected write.
  always @(negedge clk) begin
    if (axi_rstn && wready) begin
      checks++;
      assert (exp_wr.size() > 0) else begin
        errors++;
        $error("FAIL wr_unexpected: observed addr=%h data=%h expected no write", wr_addr, wdata);
      end
      if (exp_wr.size() > 0) begin
        mon_e = exp_wr.pop_front();
        checks++;
        assert ({wr_addr, wdata} === {mon_e.addr, mon_e.data}) else begin
          errors++;
          $error("FAIL wr_seq: observed addr=%h data=%h expected addr=%h data=%h",
                 wr_addr, wdata, mon_e.addr, mon_e.data);
        end
      end
    end
    if (done) done_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_w_ready"}, w_ready, 0);
    chk({tag, "_wready"}, wready, 0);
    chk({tag, "_wr_addr"}, wr_addr, 0);
    chk({tag, "_wdata"}, wdata, 0);
    chk({tag, "_araddr"}, araddr, 0);
    chk({tag, "_ph_valid"}, ph_valid, 0);
    chk({tag, "_ph_idx"}, 32'(ph_idx), 0);
    chk({tag, "_ph_data"}, ph_data, 0);
  endtask

  task automatic pulse_start(input logic [31:0] cut, input logic [31:0] mx, input logic [31:0] run);
    @(negedge clk);
    cfg_cutoff = cut; cfg_max = mx; run_cycles = run; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    cfg_cutoff = $urandom; cfg_max = $urandom; run_cycles = 32'($urandom_range(1000, 2000));
  endtask

  task automatic begin_solve(input logic [31:0] cut, input logic [31:0] mx, input logic [31:0] run);
    exp_wr.push_back('{`CTR_CUTOFF_ADDR, cut});
    exp_wr.push_back('{`CTR_MAX_ADDR, mx});
    pulse_start(cut, mx, run);
    @(negedge clk);
    chk("busy_after_start", busy, 1);
    chk("err_cleared", err, 0);
    chk("w_ready_cut", w_ready, 0);
    @(negedge clk);
    chk("w_ready_max", w_ready, 0);
    @(negedge clk);
    chk("start_latency", w_ready, 1);
  endtask

  task automatic send_w(input int i, input int j, input logic [31:0] d, input logic last);
    int t;
    w_valid = 1'b1; w_i = IW'(i); w_j = IW'(j); w_data = d; w_last = last;
    if (i <= j)
      exp_wr.push_back('{`WEIGHT_ADDR_BASE + 32'(i << 2) + 32'(j << 13), d});
    t = 0;
    while (!w_ready && t < 20) begin @(negedge clk); t++; end
    chk("w_ready_wait", w_ready, 1);
    @(posedge clk);
    #1;
    w_valid = 1'b0; w_last = 1'b0;
    if (last) exp_wr.push_back('{`START_ADDR, START_WORD});
  endtask

  task automatic finish_solve(input int run, input int bp_idx, input int bp_cycles);
    int t, dc0;
    logic [31:0] e;
    dc0 = done_cnt;
    for (int k = 0; k < N; k++) exp_ph.push_back(spin_val[k]);
    t = 0;
    do begin @(negedge clk); t++; end while (!(wready && wr_addr === `START_ADDR) && t < 50);
    chk("start_write_seen", 32'(wready && wr_addr === `START_ADDR), 1);
    t = 0;
    do begin @(negedge clk); t++; end while (araddr !== PH_FIRST && t < run + 50);
    chk("anneal_cycles", 32'(t), 32'(run + 1));
    for (int k = 0; k < N; k++) begin
      t = 0;
      while (!ph_valid && t < 50) begin @(negedge clk); t++; end
      e = (exp_ph.size() > 0) ? exp_ph.pop_front() : 32'hBAD0_BAD0;
      chk("ph_valid", ph_valid, 1);
      chk("ph_idx", 32'(ph_idx), 32'(k));
      chk("ph_data", ph_data, e);
      got_ph[k] = ph_data;
      if (k == bp_idx) begin
        for (int c = 0; c < bp_cycles; c++) begin
          @(negedge clk);
          chk("bp_valid", ph_valid, 1);
          chk("bp_idx", 32'(ph_idx), 32'(k));
          chk("bp_data", ph_data, e);
          chk("bp_araddr", araddr, `PHASE_ADDR_BASE + 32'((N - 1 - k) * 4));
        end
      end
      ph_ready = 1'b1;
      @(posedge clk);
      #1;
      ph_ready = 1'b0;
    end
    chk("done_pulse", done, 1);
    chk("busy_clear", busy, 0);
    @(posedge clk);
    #1;
    chk("done_one_cycle", done, 0);
    chk("done_once", 32'(done_cnt - dc0), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    axi_rstn = 1'b0; start = 1'b0; cfg_cutoff = '0; cfg_max = '0; run_cycles = '0;
    w_valid = 1'b0; w_i = '0; w_j = '0; w_data = '0; w_last = 1'b0; ph_ready = 1'b0;
    for (int k = 0; k < N; k++) spin_val[k] = 32'h100 + 32'(k * 17);
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    @(negedge clk);
    axi_rstn = 1'b1;

    // Max-cut A..E with local field H, B diagonal initial spin.
    spin_val[0] = 6; spin_val[1] = 2; spin_val[2] = 5; spin_val[3] = 7;
    spin_val[4] = 1; spin_val[5] = 3; spin_val[6] = 4; spin_val[7] = 8;
    begin_solve(32'd4, 32'd8, 32'd600);
    send_w(0, 1, 1, 0); send_w(0, 4, 1, 0); send_w(1, 2, 1, 0);
    send_w(1, 3, 1, 0); send_w(2, 3, 1, 0); send_w(3, 4, 1, 0);
    send_w(0, 5, 4, 0); send_w(1, 5, 4, 0); send_w(2, 5, 4, 0);
    send_w(3, 5, 4, 0); send_w(4, 5, 4, 0); send_w(1, 1, 1, 1);
    finish_solve(600, -1, 0);
    chk("maxcut_k0_ge4", 32'(got_ph[0] >= 4), 1);
    chk("maxcut_k2_ge4", 32'(got_ph[2] >= 4), 1);
    chk("maxcut_k3_ge4", 32'(got_ph[3] >= 4), 1);
    chk("maxcut_k7_ge4", 32'(got_ph[7] >= 4), 1);
    chk("maxcut_k1_le4", 32'(got_ph[1] <= 4), 1);
    chk("maxcut_k4_le4", 32'(got_ph[4] <= 4), 1);
    chk("wr_queue_empty_1", 32'(exp_wr.size()), 0);

    // Illegal entry mid-stream plus backpressure on k=3.
    for (int k = 0; k < N; k++) spin_val[k] = 32'hA000 + 32'(k * 3);
    begin_solve(32'h11, 32'h22, 32'd7);
    send_w(0, 1, 32'h33, 0);
    send_w(5, 2, 32'h44, 0);
    chk("err_set", err, 1);
    send_w(2, 6, 32'h55, 0);
    send_w(3, 7, 32'h66, 1);
    chk("err_sticky", err, 1);
    finish_solve(7, 3, 5);
    chk("err_after_done", err, 1);
    chk("wr_queue_empty_2", 32'(exp_wr.size()), 0);

    // run_cycles=0: read address one cycle after START; this start also clears err.
    for (int k = 0; k < N; k++) spin_val[k] = 32'h5000 - 32'(k * 11);
    begin_solve(32'h1, 32'h2, 32'd0);
    send_w(4, 4, 32'h7, 1);
    finish_solve(0, -1, 0);

    // Reset during LOAD (while a weight write is on the bus), then during RUN.
    begin_solve(32'h9, 32'hA, 32'd600);
    send_w(0, 2, 32'h1, 0);
    #1;
    axi_rstn = 1'b0;
    #1;
    chk_zero("rst_load");
    exp_wr.delete();
    @(negedge clk);
    axi_rstn = 1'b1;
    begin_solve(32'h9, 32'hA, 32'd600);
    send_w(1, 2, 32'h2, 1);
    repeat (20) @(negedge clk);
    chk("in_run_busy", busy, 1);
    #1;
    axi_rstn = 1'b0;
    #1;
    chk_zero("rst_run");
    exp_wr.delete();
    @(negedge clk);
    axi_rstn = 1'b1;

    // Fresh solve after reset, with start pulsed again while busy.
    for (int k = 0; k < N; k++) spin_val[k] = 32'h7700 + 32'(k * 5);
    begin_solve(32'h40, 32'h80, 32'd20);
    send_w(0, 7, 32'hC1, 0);
    pulse_start(32'hFFFF, 32'hEEEE, 32'd3);
    send_w(6, 7, 32'hC2, 0);
    pulse_start(32'hDDDD, 32'hCCCC, 32'd0);
    send_w(2, 2, 32'hC3, 1);
    finish_solve(20, -1, 0);
    chk("wr_queue_empty_3", 32'(exp_wr.size()), 0);
    repeat (10) @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("total_done", 32'(done_cnt), 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
